address_generator: RTL

//   Responder for the control unit's AG_rst / AG_read command lines. Walks the
//   (neuron, input) index space of one layer and drives input-memory and

---
 rtl/address_generator.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/address_generator.sv
// ----------------------------------------------------------------------------
// address_generator
//   Walks the (neuron, input) index space of one layer on command from the
//   control unit. Each accepted AG_read issues one read: in_addr = i and
//   w_addr = W_BASE + n*N_INPUTS + i. A valid/last delay line of MEM_LAT
//   stages follows each issue, so the ALU sees data_valid (and last_in on the
//   final input of a neuron) in the same cycle the memory data arrives.
//
// Ports
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   AG_rst           synchronous clear of the walk; wins over AG_read
//   AG_read          issue one (neuron, input) read this cycle
//   in_addr          input-memory address of the most recent issue
//   w_addr           weight-memory address of the most recent issue
//   addr_valid       in_addr/w_addr carry a read issued on the last edge
//   data_valid       addr_valid delayed by MEM_LAT cycles
//   last_in          with data_valid: final input of the current neuron
//   neuron_done      one-cycle pulse after data_valid & last_in
//   layer_done       level, all N_NEURONS*N_INPUTS reads issued
//   neuron_idx       neuron index of the most recent issue
//   ag_err           (AG_OVERRUN_ERR_EN only) sticky: AG_read seen in DONE
//
// Build option
//   AG_OVERRUN_ERR_EN  adds the ag_err output; otherwise AG_read in DONE is
//                      silently ignored.
// ----------------------------------------------------------------------------
module address_generator #(
    parameter int N_INPUTS  = 4,
    parameter int N_NEURONS = 4,
    parameter int ADDR_W    = 8,
    parameter int W_BASE    = 0,
    parameter int MEM_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              AG_rst,
    input  logic              AG_read,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic              addr_valid,
    output logic              data_valid,
    output logic              last_in,
    output logic              neuron_done,
    output logic              layer_done,
    output logic [7:0]        neuron_idx
`ifdef AG_OVERRUN_ERR_EN
    ,
    output logic              ag_err
`endif
);

    localparam int TOTAL = N_NEURONS * N_INPUTS;
    localparam int IW    = $clog2(N_INPUTS);

    // Illegal configurations are rejected at elaboration.
    if (W_BASE + TOTAL - 1 >= (1 << ADDR_W)) begin : g_addr_chk
        $error("address_generator: ADDR_W too small for W_BASE + N_NEURONS*N_INPUTS - 1");
    end
    if (N_NEURONS > 256 || N_NEURONS < 1 || N_INPUTS < 2 || MEM_LAT < 1) begin : g_param_chk
        $error("address_generator: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     i_q, i_d;
    logic [7:0]        n_q, n_d;
    logic [ADDR_W-1:0] in_addr_q, w_addr_q;
    logic [7:0]        nidx_q;
    logic [MEM_LAT:0]  vld_pipe_q;   // [0] = addr_valid, [MEM_LAT] = data_valid
    logic [MEM_LAT:0]  last_pipe_q;  // last-input tag riding with vld_pipe_q
    logic              neuron_done_q;

    logic issue, last_i, last_n, final_issue;
    logic [ADDR_W-1:0] w_next;

    assign issue       = AG_read & ~AG_rst & (state_q != S_DONE);
    assign last_i      = (i_q == IW'(N_INPUTS - 1));
    assign last_n      = (n_q == 8'(N_NEURONS - 1));
    assign final_issue = issue & last_i & last_n;

    // Deliberately computed at ADDR_W bits; the elaboration check above
    // guarantees no truncation for legal configurations.
    assign w_next = ADDR_W'(W_BASE) + ADDR_W'(n_q) * ADDR_W'(N_INPUTS) + ADDR_W'(i_q);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (AG_rst) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_RUN: if (issue) state_d = final_issue ? S_DONE : S_RUN;
                S_DONE:        state_d = S_DONE;
                default:       state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        layer_done  = (state_q == S_DONE);
        addr_valid  = vld_pipe_q[0];
        data_valid  = vld_pipe_q[MEM_LAT];
        last_in     = last_pipe_q[MEM_LAT];
        neuron_done = neuron_done_q;
        in_addr     = in_addr_q;
        w_addr      = w_addr_q;
        neuron_idx  = nidx_q;
    end

    // ---------------- index counters ----------------
    always_comb begin
        i_d = i_q;
        n_d = n_q;
        if (AG_rst) begin
            i_d = '0;
            n_d = '0;
        end else if (issue) begin
            if (last_i) begin
                i_d = '0;
                n_d = n_q + 8'd1;
            end else begin
                i_d = i_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_q <= '0;
            n_q <= '0;
        end else begin
            i_q <= i_d;
            n_q <= n_d;
        end
    end

    // ---------------- address registers (hold between issues) ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_addr_q <= '0;
            w_addr_q  <= '0;
            nidx_q    <= '0;
        end else if (issue) begin
            in_addr_q <= ADDR_W'(i_q);
            w_addr_q  <= w_next;
            nidx_q    <= n_q;
        end
    end

    // ---------------- valid / last delay line ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe_q    <= '0;
            last_pipe_q   <= '0;
            neuron_done_q <= 1'b0;
        end else if (AG_rst) begin
            // Reads still in flight are dropped with the walk.
            vld_pipe_q    <= '0;
            last_pipe_q   <= '0;
            neuron_done_q <= 1'b0;
        end else begin
            vld_pipe_q    <= {vld_pipe_q[MEM_LAT-1:0], issue};
            last_pipe_q   <= {last_pipe_q[MEM_LAT-1:0], issue & last_i};
            neuron_done_q <= vld_pipe_q[MEM_LAT] & last_pipe_q[MEM_LAT];
        end
    end

`ifdef AG_OVERRUN_ERR_EN
    logic ag_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                ag_err_q <= 1'b0;
        else if (AG_rst)                          ag_err_q <= 1'b0;
        else if (AG_read && state_q == S_DONE)    ag_err_q <= 1'b1;
    end

    assign ag_err = ag_err_q;
`endif

endmodule
